// File: rtl/data_sram_bridge.sv
// Bridges the M-stage load/store to a request/handshake SRAM-style data bus.
// One transaction in flight; the pipeline is stalled until the bus completes.
module data_sram_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en_i,
    input  logic [3:0]  mem_wen_i,
    input  logic [1:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        pipe_adv_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_stall_o,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_data_ok_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  wen_reg, wen_next;
    logic [1:0]  size_reg, size_next;
    logic [31:0] rdata_reg, rdata_next;

    logic is_read;
    assign is_read = ~(|wen_reg);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        wen_next   = wen_reg;
        size_next  = size_reg;
        rdata_next = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (mem_en_i) begin
                    addr_next  = mem_addr_i;
                    wdata_next = mem_wdata_i;
                    wen_next   = mem_wen_i;
                    size_next  = mem_size_i;
                    state_next = REQ;
                end
            end
            REQ: begin
                // A bus that answers addr_ok and data_ok together skips WAIT.
                if (data_addr_ok_i) begin
                    if (data_data_ok_i) begin
                        state_next = DONE;
                        if (is_read) rdata_next = data_rdata_i;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (data_data_ok_i) begin
                    state_next = DONE;
                    if (is_read) rdata_next = data_rdata_i;
                end
            end
            DONE: begin
                if (pipe_adv_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            wen_reg   <= 4'd0;
            size_reg  <= 2'd0;
            rdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wen_reg   <= wen_next;
            size_reg  <= size_next;
            rdata_reg <= rdata_next;
        end
    end

    assign data_req_o   = (state_reg == REQ);
    assign data_wr_o    = ~is_read;
    assign data_size_o  = size_reg;
    assign data_addr_o  = addr_reg;
    assign data_wdata_o = wdata_reg;
    assign mem_rdata_o  = rdata_reg;
    // DONE releases the stall so the instruction can leave M while data is held.
    assign mem_stall_o  = ((state_reg == IDLE) & mem_en_i)
                        | (state_reg == REQ) | (state_reg == WAIT);

endmodule

// File: doc/data_sram_bridge.md
DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 mem_en_i  input  1  M-stage instruction is a load or store.
REQ-005 mem_wen_i  input  4  byte write enables, already lane-aligned; 4'b0000 means load.
REQ-006 mem_size_i  input  2  access size: 0 byte, 1 half, 2 word; 3 is reserved.
REQ-007 mem_addr_i  input  32  byte address (aluoutM).
REQ-008 mem_wdata_i  input  32  store data, already lane-shifted.
REQ-009 pipe_adv_i  input  1  M stage advances to W this cycle (no other stall source active).
REQ-010 mem_rdata_o  output  32  captured load data to the M/W register (unmodified word).
REQ-011 mem_stall_o  output  1  M-stage stall request to the hazard unit.
REQ-012 data_req_o  output  1  bus request valid.
REQ-013 data_wr_o  output  1  bus write (1) or read (0).
REQ-014 data_size_o  output  2  bus size, copied from the latched mem_size_i.
REQ-015 data_addr_o  output  32  bus address; full byte address, low bits not masked.
REQ-016 data_wdata_o  output  32  bus write data.
REQ-017 data_addr_ok_i  input  1  bus accepted the request this cycle.
REQ-018 data_rdata_i  input  32  bus read data, valid with data_ok.
REQ-019 data_data_ok_i  input  1  bus completed the transaction this cycle.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, WAIT and DONE, with one transaction outstanding at most.
REQ-021 In IDLE with mem_en_i=1, the block SHALL latch addr, wdata, wen and size, and go to REQ on the next cycle.
REQ-022 In IDLE with mem_en_i=0, the block SHALL stay in IDLE and ignore data_addr_ok_i and data_data_ok_i.
REQ-023 In REQ the block SHALL drive data_req_o=1, with data_wr_o=|wen_latched and the bus fields from the latched values, held stable until addr_ok.
REQ-024 In REQ with addr_ok=1 and data_ok=0, the block SHALL go to WAIT.
REQ-025 In REQ with addr_ok=1 and data_ok=1 in the same cycle, the block SHALL go directly to DONE and capture rdata.
REQ-026 In REQ with addr_ok=0, the block SHALL stay in REQ with req held.
REQ-027 In WAIT the block SHALL drive data_req_o=0.
REQ-028 In WAIT with data_ok=1, the block SHALL go to DONE; for a read it SHALL also capture data_rdata_i into mem_rdata_o.
REQ-029 For a store, mem_rdata_o SHALL be unchanged.
REQ-030 In DONE, mem_rdata_o SHALL be held.
REQ-031 In DONE with pipe_adv_i=1, the block SHALL go to IDLE; with pipe_adv_i=0, it SHALL stay in DONE (external stall), with no re-issue.
REQ-032 mem_stall_o SHALL equal (IDLE & mem_en_i) | REQ | WAIT, and SHALL be 0 in DONE and in IDLE without a request.
REQ-033 Minimum stall for any access SHALL be 2 cycles (IDLE-detect, REQ with addr_ok and data_ok together); there is no upper bound.
REQ-034 In DONE the new M instruction SHALL NOT be sampled; the instruction following in M is sampled only after the return to IDLE.
REQ-035 There SHALL be no cancel path: once REQ is entered, the transaction completes before the next is accepted.
REQ-036 A data_ok received in IDLE or DONE SHALL be ignored.
REQ-037 mem_size_i=3 SHALL be passed through unchanged; checking it is the decoder's job.

Reset
REQ-038 When rst=1 at a clock edge, the block SHALL go to IDLE and set data_req_o=0, mem_rdata_o=0 and all latched fields to 0.
REQ-039 Reset SHALL take priority over every transition, including mid-REQ or mid-WAIT.
REQ-040 After a mid-transaction reset, the late data_ok of the abandoned transaction SHALL be discarded by REQ-036.

Verification
REQ-041 Load, bus answers addr_ok and data_ok together in cycle 1, rdata=0x12345678, pipe_adv_i=1 -> mem_stall_o=1 for exactly 2 cycles, mem_rdata_o=0x12345678 in DONE, IDLE next.
REQ-042 Store word addr=0x80001000, wen=4'hF, wdata=0xDEADBEEF; addr_ok after 3 wait cycles, data_ok 2 cycles later -> req held 4 cycles, data_wr_o=1 and size=2 throughout, stall released in DONE, mem_rdata_o unchanged.
REQ-043 Load completes while pipe_adv_i=0 for 3 cycles -> stays in DONE, mem_rdata_o stable, data_req_o=0, no second request issued.
REQ-044 Back-to-back: byte store (wen=4'b0100, size 0) followed by a load -> two distinct requests, second begins only after the return to IDLE, each with the correct size and wr.
REQ-045 rst asserted in WAIT, then a stray data_ok -> state IDLE, data_req_o=0, mem_rdata_o=0, stray data_ok ignored.
